// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one serial MSB-first shift-add multiplier among
// NUM_REQ requesters. Round-robin grant in IDLE, WIDTH-cycle RUN, and a
// result held in DONE until it is consumed.
// Optional: define MULT_ZERO_SKIP_EN so that a zero operand skips RUN.
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_prod,
  output logic                     busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q;
  logic [ID_W-1:0]      last_q, id_q, rsp_id_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2*WIDTH-1:0]   acc_q, rsp_prod_q;
  logic [CW-1:0]        cnt_q;
  logic                 rsp_valid_q, busy_q;

  logic [NUM_REQ-1:0][WIDTH-1:0] a_lane, b_lane;
  logic                 gnt_vld;
  logic [ID_W-1:0]      gnt;
  logic [WIDTH-1:0]     a_sel, b_sel;
  logic [2*WIDTH-1:0]   acc_d;
  logic                 hs;

  // Unpack the flattened operand buses into per-requester lanes
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign a_lane[i] = req_a[i*WIDTH +: WIDTH];
    assign b_lane[i] = req_b[i*WIDTH +: WIDTH];
  end

  // Round-robin search starting after the last grant; nearest candidate wins
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt     = ID_W'(idx);
      end
    end
  end

  assign a_sel = a_lane[gnt];
  assign b_sel = b_lane[gnt];

  // Grant is only offered while idle and out of reset
  assign req_ready = (rst_n && state_q == IDLE && gnt_vld) ? (NUM_REQ'(1) << gnt) : '0;
  assign hs        = |(req_valid & req_ready);

  // One shift-add step: double the partial sum, add a when multiplier MSB is set
  assign acc_d = {acc_q[2*WIDTH-2:0], 1'b0} + (b_q[WIDTH-1] ? {{WIDTH{1'b0}}, a_q} : '0);

  // Control FSM with registered response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      rsp_prod_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            a_q    <= a_sel;
            b_q    <= b_sel;
            id_q   <= gnt;
            last_q <= gnt;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
`ifdef MULT_ZERO_SKIP_EN
            if (a_sel == '0 || b_sel == '0) begin
              rsp_prod_q  <= '0;
              rsp_id_q    <= gnt;
              rsp_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= RUN;
            end
`else
            state_q <= RUN;
`endif
          end
        end
        RUN: begin
          acc_q <= acc_d;
          b_q   <= b_q << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            rsp_prod_q  <= acc_d;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_prod  = rsp_prod_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: randomized bench with a transaction-level model
// (round-robin pointer as an integer, product as a*b, fixed latency).
module tb_mult_share_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       req_valid;
  logic [N*W-1:0]     req_a, req_b;
  logic [N-1:0]       req_ready;
  logic               rsp_valid, rsp_ready;
  logic [IW-1:0]      rsp_id;
  logic [2*W-1:0]     rsp_prod;
  logic               busy;

  mult_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_prod(rsp_prod), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ptr;
  int hs_cyc;
  logic [W-1:0] oa [N];
  logic [W-1:0] ob [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] m);
    for (int k = 1; k <= N; k++)
      if (m[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    return ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = oa[i];
      req_b[i*W +: W] = ob[i];
    end
  endtask

  // Present a request mask, check the grant, complete the handshake
  task automatic start_txn(input logic [N-1:0] m, input bit use_f, input logic [W-1:0] fa,
                           input logic [W-1:0] fb, output int g,
                           output logic [W-1:0] ea, output logic [W-1:0] eb);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      oa[i] = use_f ? fa : rnd_op();
      ob[i] = use_f ? fb : rnd_op();
    end
    drive_ops();
    req_valid = m;
    #1;
    g = model_grant(m);
    chk("req_ready", 32'(req_ready), 32'(1) << g);
    ea = oa[g];
    eb = ob[g];
    hs_cyc = cyc;
    @(posedge clk);
    ptr = g;
    #1;
    for (int i = 0; i < N; i++) begin
      oa[i] = W'($urandom);
      ob[i] = W'($urandom);
    end
    drive_ops();
  endtask

  // Wait for the response, check it, hold it for 'hold' cycles, then consume
  task automatic finish_txn(input int g, input logic [W-1:0] ea, input logic [W-1:0] eb,
                            input int hold, input bit early);
    int n;
    int lat;
    n = 1;
    @(negedge clk);
    rsp_ready = (early && hold == 0);
    while (!rsp_valid && n < 40) begin
      chk("busy_run", 32'(busy), 1);
      chk("ready_run", 32'(req_ready), 0);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    lat = W + 1;
`ifdef MULT_ZERO_SKIP_EN
    if (ea == '0 || eb == '0) lat = 1;
`endif
    chk("latency", 32'(n), 32'(lat));
    chk("prod", 32'(rsp_prod), 32'(ea) * 32'(eb));
    chk("id", 32'(rsp_id), 32'(g));
    chk("busy_done", 32'(busy), 1);
    chk("ready_done", 32'(req_ready), 0);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_prod", 32'(rsp_prod), 32'(ea) * 32'(eb));
      chk("hold_id", 32'(rsp_id), 32'(g));
      chk("hold_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("post_valid", 32'(rsp_valid), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_prod", 32'(rsp_prod), 32'(ea) * 32'(eb));
  endtask

  initial begin
    int g, prev;
    logic [W-1:0] ea, eb;
    logic [N-1:0] m;
    int hold;

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    ptr = N - 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = '1;
    #1;
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_prod", 32'(rsp_prod), 0);
    chk("rst_id", 32'(rsp_id), 0);
    req_valid = '0;
    rst_n = 1'b1;

    // Directed operand cases
    start_txn(4'b0010, 1, 8'd13, 8'd11, g, ea, eb);
    finish_txn(g, ea, eb, 3, 0);
    start_txn(4'b0001, 1, 8'd255, 8'd255, g, ea, eb);
    finish_txn(g, ea, eb, 0, 0);
    start_txn(4'b1000, 1, 8'd1, 8'd128, g, ea, eb);
    finish_txn(g, ea, eb, 1, 0);
    start_txn(4'b0100, 1, 8'd0, 8'd77, g, ea, eb);
    finish_txn(g, ea, eb, 20, 0);

    // All requesters valid: rotating grants, back-to-back spacing
    prev = -1;
    for (int k = 0; k < 8; k++) begin
      start_txn(4'b1111, 1, 8'd200, 8'd3 + 8'(k), g, ea, eb);
      chk("rr_order", 32'(g), 32'((ptr + N) % N));
      if (prev >= 0) chk("spacing", 32'(hs_cyc - prev), W + 2);
      prev = hs_cyc;
      finish_txn(g, ea, eb, 0, k[0]);
    end

    // Valid dropped before a handshake: no side effect
    @(negedge clk);
    req_valid = 4'b0110;
    #1;
    chk("drop_ready", 32'(req_ready), 32'(1) << model_grant(4'b0110));
    req_valid = '0;
    @(posedge clk);
    #1;
    chk("drop_busy", 32'(busy), 0);

    // Randomized traffic
    for (int k = 0; k < 30; k++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      hold = $urandom_range(0, 3);
      start_txn(m, 0, '0, '0, g, ea, eb);
      finish_txn(g, ea, eb, hold, 1'($urandom));
    end

    // Reset in the middle of RUN
    start_txn(4'b0100, 0, '0, '0, g, ea, eb);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk("mrst_valid", 32'(rsp_valid), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_ready", 32'(req_ready), 0);
    chk("mrst_prod", 32'(rsp_prod), 0);
    chk("mrst_id", 32'(rsp_id), 0);
    ptr = N - 1;
    @(negedge clk);
    rst_n = 1'b1;
    start_txn(4'b0101, 0, '0, '0, g, ea, eb);
    chk("mrst_first", 32'(g), 0);
    finish_txn(g, ea, eb, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one 8-bit shift-add multiplier engine among NUM_REQ requesters.
- Each requester issues an operand pair over a valid/ready handshake. The block grants one requester round-robin, runs the serial MSB-first multiply, and returns product plus requester ID over a valid/ready response channel.
- Sits between the lab's operand sources (switch/UART/test FSMs) and the single multiplier resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width; product is 2*WIDTH bits; RUN lasts WIDTH cycles.
- ID_W, 2, width of rsp_id; must be >= clog2(NUM_REQ).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*WIDTH  flattened multiplicand; requester i at [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  flattened multiplier, same packing.
- req_ready  out  NUM_REQ  one-hot accept; at most one bit high.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumer ready.
- rsp_id  out  ID_W  index of the requester that owns rsp_prod.
- rsp_prod  out  2*WIDTH  unsigned product req_a*req_b.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rsp_valid=0, rsp_prod=0, rsp_id=0, busy=0, req_ready=0, round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - grant = first i with req_valid[i]=1, searching last+1, last+2, ... modulo NUM_REQ.
  - req_ready[grant]=1 combinationally in the same cycle. req_ready is all-zero outside IDLE or when no valid is present.
  - On handshake (req_valid[g]&req_ready[g]): latch a=req_a[g], b=req_b[g], id=g; last<=g; acc<=0; cnt<=0; go RUN.
- RUN: one cycle per multiplier bit, MSB first.
  - Each cycle: acc <= (acc<<1) + (b[WIDTH-1] ? a : 0); b <= b<<1; cnt <= cnt+1.
  - After WIDTH RUN cycles, rsp_prod<=acc result, rsp_id<=id, rsp_valid<=1, go DONE.
  - acc is 2*WIDTH bits; no overflow is possible.
- Latency: handshake in cycle 0; RUN in cycles 1..WIDTH; rsp_valid first high in cycle WIDTH+1.
- DONE:
  - rsp_valid, rsp_id and rsp_prod are held stable until rsp_ready=1.
  - On rsp_valid&rsp_ready: rsp_valid<=0 and go IDLE. rsp_prod and rsp_id keep their last value.
  - Minimum spacing between accepts is WIDTH+2 cycles.
- busy = (state!=IDLE), registered with the state.
- Boundary conditions:
  - req_valid may drop without a handshake; there is no side effect and the pointer does not move.
  - req_valid held during RUN/DONE is not accepted; it is granted on a later IDLE in round-robin order.
  - If all requesters are valid continuously, grants cycle 0,1,..,NUM_REQ-1,0; no requester starves.
  - A request asserted in the same cycle that DONE completes is not seen until the next cycle (IDLE).
  - rsp_ready high outside DONE is ignored.
  - Reset mid-RUN or mid-DONE aborts the operation: no response is produced and the pointer returns to NUM_REQ-1.
  - Operands are sampled only at handshake; later changes on req_a/req_b do not affect the result.

Optional Feature:
- Macro: MULT_ZERO_SKIP_EN.
- Defined: at handshake, if the granted req_a==0 or req_b==0, skip RUN. In the next cycle: rsp_prod=0, rsp_id=g, rsp_valid=1, state=DONE. rsp_valid is therefore first high in cycle 1. All other rules are unchanged.
- Undefined: zero operands take the full WIDTH-cycle RUN. Latency is always WIDTH+1.

Test Plan:
- Reset, then req_valid[1]=1, a1=13, b1=11 -> req_ready=4'b0010 in the same cycle; rsp_valid in cycle 9; rsp_prod=143, rsp_id=1; held until rsp_ready.
- req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; each accept 10 cycles apart; every product correct.
- a=255, b=255 -> rsp_prod=65025. a=1, b=128 -> rsp_prod=128 (checks MSB-first path).
- In DONE, hold rsp_ready=0 for 20 cycles, then pulse it -> outputs stable throughout; req_ready stays 0 throughout; IDLE the next cycle.
- Assert rst_n=0 at RUN cycle 4 with req 2 active -> outputs return to reset values immediately; after release with req_valid=4'b0101, req 0 is granted first.
- a=0, b=77 -> rsp_prod=0. With MULT_ZERO_SKIP_EN: rsp_valid in cycle 1. Without it: rsp_valid in cycle 9.
